vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_TOTAL, 800, expected pixel clocks per line (hsync falling edge to hsync falling edge).
REQ-002 Parameter V_TOTAL, 525, expected lines per frame (vsync falling edge to vsync falling edge).
REQ-003 Parameter LOCK_FRAMES, 2, consecutive good frames required to declare lock; range 1..15.
REQ-004 i_clk  input  1  single clock, one rising edge per pixel.
REQ-005 i_reset  input  1  reset, asynchronous, active-high.
REQ-006 i_hsync  input  1  horizontal sync, active-low.
REQ-007 i_vsync  input  1  vertical sync, active-low.
REQ-008 i_drawing  input  1  active-video qualifier, high during visible pixels.
REQ-009 o_x_pixel  output  10  recovered column of the current visible pixel.
REQ-010 o_y_pixel  output  10  recovered row of the current visible pixel.
REQ-011 o_valid  output  1  o_x_pixel/o_y_pixel are valid and the decoder is locked.
REQ-012 o_locked  output  1  high while the state is LOCKED.
REQ-013 o_line_len  output  10  last measured line length in clocks, saturating at 1023.
REQ-014 o_frame_lines  output  10  last measured frame length in lines, saturating at 1023.
REQ-015 o_err  output  1  one-cycle pulse on loss of lock.

Function
REQ-016 All inputs are registered once (s_*); edges are detected against a second register (p_*); falling edge = s=0 and p=1.
REQ-017 Pin-to-output latency for o_x_pixel, o_y_pixel and o_valid is exactly 2 clocks.
REQ-018 h_cnt increments every clock, saturating at 1023; on an hsync falling edge, o_line_len <= h_cnt+1 (saturating) and h_cnt <= 0.
REQ-019 v_cnt increments on each hsync falling edge, saturating at 1023; on a vsync falling edge, o_frame_lines <= v_cnt plus 1 if an hsync edge occurs in the same clock, and v_cnt <= 0.
REQ-020 x_cnt: while s_drawing=1, o_x_pixel <= x_cnt and x_cnt <= x_cnt+1; while s_drawing=0, x_cnt <= 0 and o_x_pixel holds.
REQ-021 y_cnt increments on each s_drawing falling edge and clears on a vsync falling edge; vsync wins when both occur in the same clock; o_y_pixel <= y_cnt while s_drawing=1, otherwise holds.
REQ-022 o_valid <= s_drawing AND (state==LOCKED), registered alongside o_x_pixel.
REQ-023 Bad line: hsync falling edge with h_cnt+1 != H_TOTAL, or h_cnt reaching 1023 (timeout).
REQ-024 Bad frame: vsync falling edge with measured lines != V_TOTAL, or any bad line since the previous vsync falling edge.
REQ-025 States: SEARCH, ACQUIRE, LOCKED; 4-bit good-frame counter gcnt.
REQ-026 SEARCH -> ACQUIRE on the first vsync falling edge, gcnt <= 0.
REQ-027 ACQUIRE: a good frame increments gcnt; when gcnt reaches LOCK_FRAMES, go to LOCKED; a bad frame clears gcnt and stays in ACQUIRE.
REQ-028 ACQUIRE or SEARCH: an h_cnt timeout returns to SEARCH with no o_err.
REQ-029 LOCKED: any bad line or bad frame -> SEARCH with o_err=1 for exactly one clock; o_valid drops on the following clock.
REQ-030 o_locked is a registered decode of state==LOCKED, asserted in the same clock the state enters LOCKED.

Reset
REQ-031 During i_reset: state=SEARCH; gcnt, h_cnt, v_cnt, x_cnt and y_cnt = 0; all outputs = 0; the sample and edge registers = 1 for the sync inputs and 0 for drawing (no false edge after reset).
REQ-032 Reset asserted mid-frame takes effect immediately; after release, lock requires the full SEARCH -> ACQUIRE -> LOCKED sequence.

Verification
REQ-033 Ideal 640x480 timing (800x525, drawing for h 0..639 and v 0..479) -> o_locked rises at the third vsync falling edge after reset; o_x_pixel sweeps 0..639 and o_y_pixel 0..479 with o_valid high on 307200 clocks per frame.
REQ-034 In LOCKED, one line shortened to 799 clocks -> o_line_len=799, o_err pulse of 1 clock, o_locked=0, and relock after 2 good frames.
REQ-035 In ACQUIRE, one frame of 524 lines -> o_frame_lines=524, no o_err, gcnt cleared, and lock 2 good frames later.
REQ-036 hsync held high for 2000 clocks while LOCKED -> o_line_len not updated, o_err pulses once when h_cnt reaches 1023, state=SEARCH.
REQ-037 i_reset pulsed at line 200 of a locked frame -> all outputs 0 immediately; o_locked returns at the third subsequent vsync falling edge.
REQ-038 vsync and drawing falling edges in the same clock -> y_cnt=0, and the next visible row reports o_y_pixel=0.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from VGA hsync/vsync/drawing and tracks timing lock.
// Line and frame lengths are measured against H_TOTAL/V_TOTAL before coordinates are qualified as valid.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_drawing,
  output logic [9:0] o_x_pixel,
  output logic [9:0] o_y_pixel,
  output logic       o_valid,
  output logic       o_locked,
  output logic [9:0] o_line_len,
  output logic [9:0] o_frame_lines,
  output logic       o_err
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [10:0] H_EXP   = 11'(H_TOTAL);
  localparam logic [9:0]  V_EXP   = 10'(V_TOTAL);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  state_t     state, next_state;
  logic [3:0] gcnt, gcnt_next, gcnt_inc;
  logic       err_next, locked_next;

  logic s_hsync, s_vsync, s_drawing;
  logic p_hsync, p_vsync, p_drawing;
  logic h_fall, v_fall, d_fall;

  logic [9:0] h_cnt, v_cnt, x_cnt, y_cnt;
  logic [9:0] h_len, frame_meas;
  logic       bad_seen, h_timeout, bad_line, bad_frame;

  assign h_fall = !s_hsync && p_hsync;
  assign v_fall = !s_vsync && p_vsync;
  assign d_fall = !s_drawing && p_drawing;

  assign h_len      = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1;
  assign frame_meas = (h_fall && v_cnt != CNT_MAX) ? v_cnt + 10'd1 : v_cnt;
  // Timeout fires once, on the clock that carries h_cnt into saturation.
  assign h_timeout  = (h_cnt == 10'd1022) && !h_fall;
  assign bad_line   = (h_fall && (({1'b0, h_cnt} + 11'd1) != H_EXP)) || h_timeout;
  assign bad_frame  = v_fall && ((frame_meas != V_EXP) || bad_seen || bad_line);
  assign gcnt_inc   = gcnt + 4'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s_hsync   <= 1'b1;
      s_vsync   <= 1'b1;
      s_drawing <= 1'b0;
      p_hsync   <= 1'b1;
      p_vsync   <= 1'b1;
      p_drawing <= 1'b0;
    end else begin
      s_hsync   <= i_hsync;
      s_vsync   <= i_vsync;
      s_drawing <= i_drawing;
      p_hsync   <= s_hsync;
      p_vsync   <= s_vsync;
      p_drawing <= s_drawing;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      o_line_len    <= '0;
      o_frame_lines <= '0;
      bad_seen      <= 1'b0;
    end else begin
      if (h_fall) begin
        o_line_len <= h_len;
        h_cnt      <= '0;
      end else if (h_cnt != CNT_MAX) begin
        h_cnt <= h_cnt + 10'd1;
      end
      if (v_fall) begin
        o_frame_lines <= frame_meas;
        v_cnt         <= '0;
      end else if (h_fall && v_cnt != CNT_MAX) begin
        v_cnt <= v_cnt + 10'd1;
      end
      if (v_fall) bad_seen <= 1'b0;
      else if (bad_line) bad_seen <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      o_x_pixel <= '0;
      o_y_pixel <= '0;
      o_valid   <= 1'b0;
    end else begin
      if (s_drawing) begin
        o_x_pixel <= x_cnt;
        o_y_pixel <= y_cnt;
        x_cnt     <= x_cnt + 10'd1;
      end else begin
        x_cnt <= '0;
      end
      if (v_fall) y_cnt <= '0;
      else if (d_fall) y_cnt <= y_cnt + 10'd1;
      o_valid <= s_drawing && (state == LOCKED);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= SEARCH;
      gcnt     <= '0;
      o_err    <= 1'b0;
      o_locked <= 1'b0;
    end else begin
      state    <= next_state;
      gcnt     <= gcnt_next;
      o_err    <= err_next;
      o_locked <= locked_next;
    end
  end

  always_comb begin
    next_state = state;
    gcnt_next  = gcnt;
    unique case (state)
      SEARCH: begin
        if (!h_timeout && v_fall) begin
          next_state = ACQUIRE;
          gcnt_next  = '0;
        end
      end
      ACQUIRE: begin
        if (h_timeout) begin
          next_state = SEARCH;
        end else if (v_fall) begin
          if (bad_frame) begin
            gcnt_next = '0;
          end else begin
            gcnt_next = gcnt_inc;
            if (gcnt_inc >= LOCK_N) next_state = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (bad_line || bad_frame) next_state = SEARCH;
      end
      default: next_state = SEARCH;
    endcase
  end

  always_comb begin
    err_next    = (state == LOCKED) && (next_state == SEARCH);
    locked_next = (next_state == LOCKED);
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled 20x10 timing (16x8 visible) to keep runs short.
module tb_vga_sync_decoder;

  localparam int HT = 20;
  localparam int VT = 10;

  logic       i_clk, i_reset, i_hsync, i_vsync, i_drawing;
  logic [9:0] o_x_pixel, o_y_pixel, o_line_len, o_frame_lines;
  logic       o_valid, o_locked, o_err;

  int tests_run = 0;
  int tests_failed = 0;

  int  valid_total = 0, err_total = 0, lat_mism = 0;
  int  last_x = 0, last_y = 0, rise_x = -1, rise_y = -1;
  logic prev_valid = 1'b0;
  logic lat_en = 1'b0;
  logic drw_d1 = 1'b0, drw_d2 = 1'b0;
  int  v0, e0;

  vga_sync_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_drawing(i_drawing), .o_x_pixel(o_x_pixel), .o_y_pixel(o_y_pixel),
    .o_valid(o_valid), .o_locked(o_locked), .o_line_len(o_line_len),
    .o_frame_lines(o_frame_lines), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    drw_d1 <= i_drawing;
    drw_d2 <= drw_d1;
  end

  always @(negedge i_clk) begin
    if (o_valid) begin
      valid_total++;
      last_x = int'(o_x_pixel);
      last_y = int'(o_y_pixel);
      if (!prev_valid) begin
        rise_x = int'(o_x_pixel);
        rise_y = int'(o_y_pixel);
      end
    end
    if (o_err) err_total++;
    if (lat_en && (o_valid != drw_d2)) lat_mism++;
    prev_valid = o_valid;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  // Visible area: columns 4..19 of lines vis..vis+7; sync pulses start at column 0 / line 0.
  task automatic drive(input int hc, input int l, input int vis);
    @(posedge i_clk); #1;
    i_hsync   = (hc >= 3);
    i_vsync   = (l >= 2);
    i_drawing = (hc >= 4) && (l >= vis) && (l < vis + 8);
  endtask

  task automatic run_lines(input int first, input int last, input int short_l, input int vis);
    for (int l = first; l <= last; l++)
      for (int hc = 0; hc < ((l == short_l) ? HT - 1 : HT); hc++)
        drive(hc, l, vis);
    @(negedge i_clk); #1;
  endtask

  task automatic run_frame(input int nlines, input int vis);
    run_lines(0, nlines - 1, -1, vis);
  endtask

  initial begin
    i_reset = 1'b1; i_hsync = 1'b1; i_vsync = 1'b1; i_drawing = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk); #1;
    check("rst_x", int'(o_x_pixel), 0);
    check("rst_y", int'(o_y_pixel), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_locked", int'(o_locked), 0);
    check("rst_line_len", int'(o_line_len), 0);
    check("rst_frame_lines", int'(o_frame_lines), 0);
    check("rst_err", int'(o_err), 0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    // Initial acquisition: lock at the third vsync falling edge
    run_frame(VT, 1);
    run_frame(VT, 1);
    check("lock_after_2_frames", int'(o_locked), 0);
    v0 = valid_total;
    run_frame(VT, 1);
    check("lock_at_3rd_vsync", int'(o_locked), 1);
    check("valid_count", valid_total - v0, 128);
    check("last_x", last_x, 15);
    check("last_y", last_y, 7);
    check("line_len", int'(o_line_len), 20);
    check("frame_lines", int'(o_frame_lines), 10);
    check("no_err_ideal", err_total, 0);
    lat_en = 1'b1;
    run_frame(VT, 1);
    lat_en = 1'b0;
    check("latency_2clk", lat_mism, 0);

    // One short line while locked
    e0 = err_total;
    run_lines(0, 6, 5, 1);
    check("short_line_len", int'(o_line_len), 19);
    check("short_err_pulses", err_total - e0, 1);
    check("short_unlocked", int'(o_locked), 0);
    run_lines(7, 9, -1, 1);
    run_frame(VT, 1);
    run_frame(VT, 1);
    check("short_relock_early", int'(o_locked), 0);
    run_frame(VT, 1);
    check("short_relock", int'(o_locked), 1);

    // hsync stuck high while locked
    e0 = err_total;
    repeat (2000) begin
      @(posedge i_clk); #1;
      i_hsync = 1'b1; i_vsync = 1'b1; i_drawing = 1'b0;
    end
    @(negedge i_clk); #1;
    check("timeout_err_pulses", err_total - e0, 1);
    check("timeout_line_len_held", int'(o_line_len), 20);
    check("timeout_unlocked", int'(o_locked), 0);
    check("timeout_valid", int'(o_valid), 0);

    // Recovery with one 9-line frame during acquisition
    e0 = err_total;
    run_lines(0, 0, -1, 1);
    check("line_len_saturated", int'(o_line_len), 1023);
    run_lines(1, VT - 1, -1, 1);
    run_frame(VT - 1, 1);
    run_frame(VT, 1);
    check("short_frame_lines", int'(o_frame_lines), 9);
    check("short_frame_no_err", err_total - e0, 0);
    check("short_frame_unlocked", int'(o_locked), 0);
    run_frame(VT, 1);
    check("acq_relock_early", int'(o_locked), 0);
    run_frame(VT, 1);
    check("acq_relock", int'(o_locked), 1);

    // Asynchronous reset in the middle of a locked frame
    run_lines(0, 4, -1, 1);
    check("pre_reset_valid", int'(o_valid), 1);
    i_reset = 1'b1;
    #1;
    check("mid_rst_valid", int'(o_valid), 0);
    check("mid_rst_locked", int'(o_locked), 0);
    check("mid_rst_x", int'(o_x_pixel), 0);
    check("mid_rst_line_len", int'(o_line_len), 0);
    check("mid_rst_frame_lines", int'(o_frame_lines), 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    run_lines(5, 9, -1, 1);
    run_frame(VT, 1);
    run_frame(VT, 1);
    check("post_rst_lock_early", int'(o_locked), 0);
    run_frame(VT, 1);
    check("post_rst_lock", int'(o_locked), 1);

    // Last visible row ends on the vsync falling edge
    run_frame(VT, 2);
    check("coincide_last_y", last_y, 7);
    run_lines(0, 1, -1, 1);
    check("coincide_first_y", rise_y, 0);
    check("coincide_first_x", rise_x, 0);
    run_lines(2, VT - 1, -1, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
